// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: operating modes and
// burst controller states.
package shift_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Only the two shift modes describe a burst that actually moves data.
    function automatic logic is_shift(input mode_e m);
        return (m == SHR) || (m == SHL);
    endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register; master drives the
// operation, slave is the register itself.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             en;
    logic [1:0]       mode;
    logic             si_r;
    logic             si_l;
    logic [WIDTH-1:0] pin;
    logic             start;
    logic [CNT_W-1:0] len;
    logic [WIDTH-1:0] q;
    logic             so_r;
    logic             so_l;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, si_r, si_l, pin, start, len,
        input  q, so_r, so_l, busy, done
    );

    modport slave (
        input  en, mode, si_r, si_l, pin, start, len,
        output q, so_r, so_l, busy, done
    );
endinterface

// File: rtl/shift_burst_ctrl.sv
// Burst sequencer: accepts a start in IDLE, issues len shift strobes in the
// latched direction, then a single FIN cycle that raises done.
module shift_burst_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  mode_e            mode,
    output logic             shift_en,
    output logic             dir,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] len_clamped;

    // A request longer than the register is the same as a full flush.
    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d = (mode == SHL) ? DIR_LEFT : DIR_RIGHT;
                    if ((len_clamped == '0) || !is_shift(mode)) begin
                        state_d = FIN;
                        cnt_d   = '0;
                    end else begin
                        state_d = RUN;
                        cnt_d   = len_clamped;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status flags are registered copies of the upcoming state.
        busy_d = (state_d == RUN);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign shift_en = (state_q == RUN);
    assign dir      = dir_q;
    assign busy     = busy_q;
    assign done     = done_q;

    a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(busy_q && done_q));
    a_done_pulse:     assert property (@(posedge clk) disable iff (!rst_n) done_q |=> !done_q);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register datapath: manual hold/shift/load while idle, plus
// counted shift bursts sequenced by shift_burst_ctrl.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic              clk,
    input logic              rst_n,
    univ_shift_reg_if.slave  bus
);

    if (WIDTH < 2) begin : g_width_chk
        $error("univ_shift_reg: WIDTH must be at least 2");
    end

    mode_e            mode;
    logic             shift_en;
    logic             dir;
    logic             busy;
    logic             done;
    logic             idle;
    logic [WIDTH-1:0] q_q, q_d;

    assign mode = mode_e'(bus.mode);

    shift_burst_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (bus.start),
        .len      (bus.len),
        .mode     (mode),
        .shift_en (shift_en),
        .dir      (dir),
        .busy     (busy),
        .done     (done)
    );

    // IDLE is the only state with both flags low.
    assign idle = !busy && !done;

    always_comb begin
        q_d = q_q;
        if (shift_en) begin
            q_d = (dir == DIR_LEFT) ? {q_q[WIDTH-2:0], bus.si_l}
                                    : {bus.si_r, q_q[WIDTH-1:1]};
        end else if (idle && !bus.start && bus.en) begin
            case (mode)
                SHR:     q_d = {bus.si_r, q_q[WIDTH-1:1]};
                SHL:     q_d = {q_q[WIDTH-2:0], bus.si_l};
                LOAD:    q_d = bus.pin;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign bus.q    = q_q;
    assign bus.so_r = q_q[0];
    assign bus.so_l = q_q[WIDTH-1];
    assign bus.busy = busy;
    assign bus.done = done;

endmodule
